// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor: operands and start in,
// busy/done handshake and the registered result out.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH clocks using a
// single full-subtractor cell and one borrow flip-flop.
//
// state | meaning
// IDLE  | waiting for start; results from the last completion are held
// RUN   | one bit per clock; finishes on the edge where count == WIDTH-1
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   sub_if
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q,  a_sr_d;
    logic [WIDTH-1:0] b_sr_q,  b_sr_d;
    logic [WIDTH-1:0] res_q,   res_d;
    logic             br_q,    br_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q,  diff_d;
    logic             bout_q,  bout_d;
    logic             ovf_q,   ovf_d;
    logic             done_q,  done_d;

    logic x_bit, y_bit, d_bit, br_next;

    always_comb begin
        x_bit   = a_sr_q[0];
        y_bit   = b_sr_q[0];
        d_bit   = x_bit ^ y_bit ^ br_q;
        br_next = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_q);
    end

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (sub_if.start) begin
                    state_d = S_RUN;
                    a_sr_d  = sub_if.a;
                    b_sr_d  = sub_if.b;
                    br_d    = sub_if.bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    a_msb_d = sub_if.a[WIDTH-1];
                    b_msb_d = sub_if.b[WIDTH-1];
                end
            end

            S_RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                res_d  = {d_bit, res_q[WIDTH-1:1]};
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // d_bit is the result MSB on this final edge
                    state_d = S_IDLE;
                    diff_d  = {d_bit, res_q[WIDTH-1:1]};
                    bout_d  = br_next;
                    ovf_d   = (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
                    done_d  = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign sub_if.busy = (state_q == S_RUN);
    assign sub_if.done = done_q;
    assign sub_if.diff = diff_q;
    assign sub_if.bout = bout_q;
    assign sub_if.ovf  = ovf_q;
endmodule
